pipelined_adder: RTL and testbench

//   Parametrised WIDTH-bit adder split into STAGES carry-pipelined chunks, with a

---
 rtl/pipelined_adder_pkg.sv | 14 +
 rtl/adder_stage.sv | 83 ++++++++
 rtl/pipelined_adder.sv | 100 ++++++++++
 tb/tb_pipelined_adder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and configuration check.
package pipelined_adder_pkg;

  // Bits handled by each pipeline stage.
  function automatic int unsigned chunk_of(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? 0 : width / stages;
  endfunction

  // True when the WIDTH/STAGES pair splits into equal, non-empty chunks.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (width % stages == 0) && (width >= stages);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One carry-pipelined chunk of the adder. Adds chunk [LO +: CHUNK] of a/b plus
// the incoming carry, registers the partial sum and carry-out, and forwards the
// operand bits that later stages still need. Optional ADDER_OVF_EN adds a signed
// overflow flag, registered only by the stage that owns the MSB.
module adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned CHUNK = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LO    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v_in,
  input  logic             adv,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] s_in,
  input  logic             c_in,
  output logic             ld,
  output logic             v_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  // Operand bits above this stage's chunk; lower bits are already consumed and
  // are forwarded as constant zero so synthesis trims those skew flops.
  localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << (LO + CHUNK);

  logic [CHUNK:0]   part;
  logic [WIDTH-1:0] s_nxt;

  // Chunk add and merge into the completed lower sum bits.
  always_comb begin
    part  = {1'b0, a_in[LO +: CHUNK]} + {1'b0, b_in[LO +: CHUNK]} + {{CHUNK{1'b0}}, c_in};
    s_nxt = s_in;
    s_nxt[LO +: CHUNK] = part[CHUNK-1:0];
  end

  // Stage may load when empty or when its current content moves on.
  assign ld = ~v_out | adv;

  // Valid bit and data/skew registers; data only updates on a real transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_out <= 1'b0;
      a_out <= '0;
      b_out <= '0;
      s_out <= '0;
      c_out <= 1'b0;
    end else if (ld) begin
      v_out <= v_in;
      if (v_in) begin
        a_out <= a_in & HI_MASK;
        b_out <= b_in & HI_MASK;
        s_out <= s_nxt;
        c_out <= part[CHUNK];
      end
    end
  end

`ifdef ADDER_OVF_EN
  if (LO + CHUNK == WIDTH) begin : g_ovf
    // Signed overflow from the sign bits seen by the MSB-owning stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovf_out <= 1'b0;
      end else if (ld && v_in) begin
        ovf_out <= (a_in[WIDTH-1] == b_in[WIDTH-1]) && (s_nxt[WIDTH-1] != a_in[WIDTH-1]);
      end
    end
  end else begin : g_no_ovf
    assign ovf_out = 1'b0;
  end
`endif

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES carry-pipelined chunks with valid/ready
// handshake on both sides; one add per clock, latency STAGES.
// Optional feature macro: ADDER_OVF_EN (adds the signed overflow output ovf).
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CHUNK = chunk_of(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES >= 1");
  end

  // Index k feeds stage k; index STAGES is the pipeline output.
  logic [WIDTH-1:0] a_p [STAGES+1];
  logic [WIDTH-1:0] b_p [STAGES+1];
  logic [WIDTH-1:0] s_p [STAGES+1];
  logic [STAGES:0]  v_p;
  logic [STAGES:0]  c_p;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] adv;
`ifdef ADDER_OVF_EN
  logic [STAGES-1:0] ovf_p;
`endif

  assign v_p[0] = in_valid;
  assign a_p[0] = a;
  assign b_p[0] = b;
  assign s_p[0] = '0;
  assign c_p[0] = cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Content of stage k moves on when the consumer (last) or stage k+1 takes it.
    if (k == STAGES - 1) begin : g_last
      assign adv[k] = v_p[k+1] & out_ready;
    end else begin : g_mid
      assign adv[k] = v_p[k+1] & ld[k+1];
    end

    adder_stage #(
      .CHUNK (CHUNK),
      .WIDTH (WIDTH),
      .LO    (k * CHUNK)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .v_in    (v_p[k]),
      .adv     (adv[k]),
      .a_in    (a_p[k]),
      .b_in    (b_p[k]),
      .s_in    (s_p[k]),
      .c_in    (c_p[k]),
      .ld      (ld[k]),
      .v_out   (v_p[k+1]),
      .a_out   (a_p[k+1]),
      .b_out   (b_p[k+1]),
      .s_out   (s_p[k+1]),
      .c_out   (c_p[k+1])
`ifdef ADDER_OVF_EN
      ,
      .ovf_out (ovf_p[k])
`endif
    );
  end

  assign in_ready  = ld[0];
  assign out_valid = v_p[STAGES];
  assign sum       = s_p[STAGES];
  assign cout      = c_p[STAGES];

  // Final-stage operand skew outputs are always zero and intentionally unread.
`ifdef ADDER_OVF_EN
  assign ovf = ovf_p[STAGES-1];
  logic unused_fwd;
  assign unused_fwd = ^{a_p[STAGES], b_p[STAGES], ovf_p};
`else
  logic unused_fwd;
  assign unused_fwd = ^{a_p[STAGES], b_p[STAGES]};
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed testbench for pipelined_adder (WIDTH=8, STAGES=2).
module tb_pipelined_adder;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_OVF_EN
  logic             ovf;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipelined_adder #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++;
    if (sum !== 8'h00) begin tests_failed++; $display("FAIL reset_sum: got %h want 00", sum); end
    tests_run++;
    if (cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout: got %b want 0", cout); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle: got %b want 0", out_valid); end
  endtask

  // Sweep all a with 16 b values and both cin; full throughput, fixed latency.
  task automatic test_sweep();
    localparam int N = 256 * 16 * 2;
    logic [8:0] q[$];
    logic [8:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = q.pop_front();
        tests_run++;
        if ({out_valid, cout, sum} !== {1'b1, e}) begin
          tests_failed++;
          $display("FAIL sweep_result op%0d: got v=%b %b_%h want v=1 %b_%h", i - 2, out_valid, cout, sum, e[8], e[7:0]);
        end
      end
      if (i < N) begin
        in_valid = 1'b1;
        a   = 8'(i / 32);
        b   = 8'(((i / 2) % 16) * 17);
        cin = 1'(i % 2);
        q.push_back({1'b0, a} + {1'b0, b} + {8'b0, cin});
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL sweep_in_ready op%0d: got %b want 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL sweep_drain: got %b want 0", out_valid); end
  endtask

  // Hand-computed boundary vectors: wrap, chunk-boundary carry, cin only.
  task automatic test_wrap();
    logic [7:0] va [5] = '{8'hFF, 8'h0F, 8'h00, 8'hAA, 8'hFF};
    logic [7:0] vb [5] = '{8'h01, 8'h01, 8'h00, 8'h55, 8'hFF};
    logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] es [5] = '{8'h00, 8'h10, 8'h01, 8'h00, 8'hFF};
    logic       ec [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int w;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vc[i];
      @(negedge clk);
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 10) begin @(negedge clk); w++; end
      tests_run++;
      if (w !== STAGES - 1) begin tests_failed++; $display("FAIL wrap_latency v%0d: got %0d want %0d", i, w + 1, STAGES); end
      tests_run++;
      if ({cout, sum} !== {ec[i], es[i]}) begin
        tests_failed++;
        $display("FAIL wrap_result v%0d: got %b_%h want %b_%h", i, cout, sum, ec[i], es[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_s [3] = '{8'h02, 8'h04, 8'h06};
    int sent = 0, got = 0, cyc = 0;
    bit saw_full = 0;
    while (got < 3 && cyc < 50) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (sent < 3) begin
        in_valid = 1'b1; a = 8'(sent + 1); b = 8'(sent + 1); cin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) saw_full = 1;
      if (cyc == 4) begin
        tests_run++;
        if ({out_valid, sum, in_ready} !== {1'b1, 8'h02, 1'b0}) begin
          tests_failed++;
          $display("FAIL bp_stalled: got v=%b sum=%h rdy=%b want v=1 sum=02 rdy=0", out_valid, sum, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        tests_run++;
        if (sum !== exp_s[got]) begin tests_failed++; $display("FAIL bp_order #%0d: got %h want %h", got, sum, exp_s[got]); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    tests_run++;
    if (got !== 3) begin tests_failed++; $display("FAIL bp_count: got %0d want 3", got); end
    tests_run++;
    if (saw_full !== 1'b1) begin tests_failed++; $display("FAIL bp_in_ready_low: got %b want 1", saw_full); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    localparam int N = 2000;
    logic [8:0] q[$];
    logic [8:0] e;
    logic [8:0] prev_out = '0;
    logic       prev_stall = 1'b0;
    int sent = 0, got = 0, cyc = 0;
    while (got < N && cyc < 20000) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (sent < N) begin
        in_valid = 1'($urandom_range(0, 1));
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        tests_run++;
        if ({out_valid, cout, sum} !== {1'b1, prev_out}) begin
          tests_failed++;
          $display("FAIL rnd_hold cyc%0d: got v=%b %b_%h want v=1 %b_%h", cyc, out_valid, cout, sum, prev_out[8], prev_out[7:0]);
        end
      end
      if (out_valid && out_ready) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("FAIL rnd_extra cyc%0d: got %b_%h want none", cyc, cout, sum);
        end else begin
          e = q.pop_front();
          if ({cout, sum} !== e) begin
            tests_failed++;
            $display("FAIL rnd_result #%0d: got %b_%h want %b_%h", got, cout, sum, e[8], e[7:0]);
          end
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {cout, sum};
      if (in_valid && in_ready) begin
        q.push_back({1'b0, a} + {1'b0, b} + {8'b0, cin});
        sent++;
      end
      cyc++;
    end
    tests_run++;
    if (got !== N) begin tests_failed++; $display("FAIL rnd_count: got %0d want %0d", got, N); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rnd_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    bit stale = 0;
    int w;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    @(negedge clk);
    a = 8'h30; b = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_inflight: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, sum, cout, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_reset_now: got v=%b sum=%h c=%b rdy=%b want v=0 sum=00 c=0 rdy=1", out_valid, sum, cout, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1;
    end
    tests_run++;
    if (stale !== 1'b0) begin tests_failed++; $display("FAIL mid_no_stale: got %b want 0", stale); end
    in_valid = 1'b1; a = 8'h21; b = 8'h21; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin @(negedge clk); w++; end
    tests_run++;
    if ({out_valid, cout, sum} !== {1'b1, 1'b0, 8'h42}) begin
      tests_failed++;
      $display("FAIL mid_recover: got v=%b %b_%h want v=1 0_42", out_valid, cout, sum);
    end
  endtask

`ifdef ADDER_OVF_EN
  task automatic test_ovf();
    logic [7:0] va [3] = '{8'h7F, 8'h80, 8'h7F};
    logic [7:0] vb [3] = '{8'h01, 8'h80, 8'h80};
    logic [7:0] es [3] = '{8'h80, 8'h00, 8'hFF};
    logic       ec [3] = '{1'b0, 1'b1, 1'b0};
    logic       eo [3] = '{1'b1, 1'b1, 1'b0};
    int w;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = va[i]; b = vb[i]; cin = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 10) begin @(negedge clk); w++; end
      tests_run++;
      if ({out_valid, ovf, cout, sum} !== {1'b1, eo[i], ec[i], es[i]}) begin
        tests_failed++;
        $display("FAIL ovf_v%0d: got v=%b ovf=%b %b_%h want v=1 ovf=%b %b_%h", i, out_valid, ovf, cout, sum, eo[i], ec[i], es[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_wrap();
    test_backpressure();
    test_random();
    test_reset_midflight();
`ifdef ADDER_OVF_EN
    test_ovf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
